// File: rtl/seq_chain_monitor.sv
// Multi-channel checker for linear sequences ev[0] ##1 ev[1] ##1 ... ##1 ev[LEN-1].
// Every channel starts a new overlapping attempt on each sampling edge.

module seq_chain_monitor #(
  parameter int unsigned CH        = 4,
  parameter int unsigned LEN       = 3,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned EDGE_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr_cnt,
  input  logic [CH*LEN-1:0]     ev,
  output logic [CH-1:0]         match,
  output logic [CH-1:0]         fail,
  output logic                  any_match,
  output logic [CH*CNT_W-1:0]   match_cnt
);

  // All state flops share one sampling clock; negedge mode simply inverts clk.
  logic sclk;
  assign sclk = (EDGE_MODE != 0) ? ~clk : clk;

  logic [CH-1:0][LEN-2:0]  att_q, att_d;
  logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CH-1:0]           hit, fail_d;
  logic [CH-1:0]           match_q, fail_q;
  logic                    any_q;

  always_comb begin
    att_d  = '0;
    hit    = '0;
    fail_d = '0;
    cnt_d  = cnt_q;
    for (int c = 0; c < CH; c++) begin
      att_d[c][0] = ev[c*LEN];
      for (int k = 1; k < LEN - 1; k++) begin
        att_d[c][k] = att_q[c][k-1] & ev[c*LEN+k];
      end
      hit[c] = att_q[c][LEN-2] & ev[c*LEN+LEN-1];
      for (int k = 1; k < LEN; k++) begin
        fail_d[c] = fail_d[c] | (att_q[c][k-1] & ~ev[c*LEN+k]);
      end
    end
    // Disable kills every in-flight attempt and suppresses reporting.
    if (!en) begin
      att_d  = '0;
      hit    = '0;
      fail_d = '0;
    end
    for (int c = 0; c < CH; c++) begin
      if (clr_cnt) begin
        cnt_d[c] = '0;
      end else if (hit[c] && (cnt_q[c] != '1)) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      att_q   <= '0;
      cnt_q   <= '0;
      match_q <= '0;
      fail_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      att_q   <= att_d;
      cnt_q   <= cnt_d;
      match_q <= hit;
      fail_q  <= fail_d;
      any_q   <= |hit;
    end
  end

  assign match     = match_q;
  assign fail      = fail_q;
  assign any_match = any_q;
  assign match_cnt = cnt_q;

endmodule
